cv32e40p_mult_tmr_ctrl: RTL and testbench

CV32E40P_MULT_TMR_CTRL -- requirements
Module: cv32e40p_mult_tmr_ctrl

---
 rtl/cv32e40p_pkg.sv | 17 +
 rtl/cv32e40p_tmr_voter.sv | 32 +++
 rtl/cv32e40p_mult_tmr_ctrl.sv | 157 +++++++++++++++
 tb/tb_cv32e40p_mult_tmr_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types and constants for the triplicated multiplier controller
package cv32e40p_pkg;

  localparam int unsigned TMR_LANES = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RETRY,
    FATAL
  } tmr_state_e;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_voter.sv
// rtl/cv32e40p_tmr_voter.sv - combinational 2-of-3 vote / 2-lane select and per-lane disagreement
module cv32e40p_tmr_voter
  import cv32e40p_pkg::*;
(
  input  logic [TMR_LANES-1:0]       act_i,
  input  logic [TMR_LANES-1:0][31:0] result_i,
  output logic [31:0]                result_o,
  output logic [TMR_LANES-1:0]       mismatch_o,
  output logic                       disagree_o
);

  always_comb begin
    result_o   = result_i[0];
    mismatch_o = '0;
    if (&act_i) begin
      result_o = (result_i[0] & result_i[1]) | (result_i[0] & result_i[2]) |
                 (result_i[1] & result_i[2]);
    end else if (act_i[0]) begin
      result_o = result_i[0];
    end else if (act_i[1]) begin
      result_o = result_i[1];
    end else begin
      result_o = result_i[2];
    end
    for (int i = 0; i < TMR_LANES; i++) begin
      mismatch_o[i] = act_i[i] && (result_i[i] != result_o);
    end
    // With two lanes the select picks the lower one, so any mismatch means they differ.
    disagree_o = (popcnt3(act_i) == 2'd2) && (|mismatch_o);
  end

endmodule

// File: rtl/cv32e40p_mult_tmr_ctrl.sv
// rtl/cv32e40p_mult_tmr_ctrl.sv - TMR controller: voting, fault counting, lane retirement, retry and fatal handling
module cv32e40p_mult_tmr_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned FAULT_THRESH = 3,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable_i,
  input  logic                             ex_ready_i,
  input  logic                             clear_i,
  input  logic [TMR_LANES-1:0][31:0]       result_i,
  input  logic [TMR_LANES-1:0]             ready_i,
  input  logic [TMR_LANES-1:0]             multicycle_i,
  input  logic [TMR_LANES-1:0]             mulh_active_i,
  output logic [31:0]                      result_o,
  output logic                             ready_o,
  output logic                             multicycle_o,
  output logic                             mulh_active_o,
  output logic                             retry_o,
  output logic [TMR_LANES-1:0]             lane_mask_o,
  output logic [TMR_LANES-1:0]             mismatch_o,
  output logic                             fatal_o,
  output logic [TMR_LANES-1:0][CNT_W-1:0]  fault_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  tmr_state_e                      state_q, state_d;
  logic [TMR_LANES-1:0]            lane_mask_q, lane_mask_d;
  logic [TMR_LANES-1:0]            excl_q, excl_d;
  logic [TMR_LANES-1:0]            mismatch_q, mismatch_d;
  logic [TMR_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0]               wait_q, wait_d;
  logic                            retried_q, retried_d;
  logic                            mc_q, mc_d, mh_q, mh_d;

  logic [TMR_LANES-1:0] act, hit, vote_mismatch;
  logic                 vote_disagree, in_op, all_rdy, any_rdy;
  logic                 disagree, complete, partial, timeout;

  // Lanes excluded by a readiness timeout sit out only the current operation.
  assign act = lane_mask_q & ~excl_q;

  cv32e40p_tmr_voter u_voter (
    .act_i      (act),
    .result_i   (result_i),
    .result_o   (result_o),
    .mismatch_o (vote_mismatch),
    .disagree_o (vote_disagree)
  );

  always_comb begin
    in_op    = (state_q == IDLE) || (state_q == BUSY);
    all_rdy  = &(ready_i | ~act);
    any_rdy  = |(ready_i & act);
    disagree = in_op && enable_i && all_rdy && vote_disagree;
    ready_o  = in_op && all_rdy && !disagree;
    complete = enable_i && ready_o && ex_ready_i;
    partial  = in_op && enable_i && any_rdy && !all_rdy;
    timeout  = partial && (wait_q == WAIT_W'(MAX_WAIT));
  end

  always_comb begin
    state_d     = state_q;
    lane_mask_d = lane_mask_q;
    excl_d      = excl_q;
    cnt_d       = cnt_q;
    retried_d   = retried_q;
    wait_d      = '0;
    hit         = '0;
    mc_d        = |(multicycle_i & act);
    mh_d        = |(mulh_active_i & act);

    case (state_q)
      IDLE, BUSY: begin
        if (!enable_i) begin
          state_d   = IDLE;
          excl_d    = '0;
          retried_d = 1'b0;
        end else if (disagree) begin
          state_d   = retried_q ? FATAL : RETRY;
          retried_d = 1'b1;
        end else if (complete) begin
          hit       = vote_mismatch;
          state_d   = IDLE;
          excl_d    = '0;
          retried_d = 1'b0;
        end else if (timeout) begin
          hit     = act & ~ready_i;
          excl_d  = excl_q | hit;
          state_d = BUSY;
        end else if (!all_rdy) begin
          state_d = BUSY;
          if (partial) wait_d = wait_q + WAIT_W'(1);
        end
      end
      RETRY:   state_d = BUSY;
      FATAL:   state_d = FATAL;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < TMR_LANES; i++) begin
      if (hit[i]) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (32'(cnt_d[i]) >= FAULT_THRESH) lane_mask_d[i] = 1'b0;
      end
    end
    if ((hit != '0) && (popcnt3(lane_mask_d & ~excl_d) < 2'd2)) state_d = FATAL;
    mismatch_d = hit;

    if (clear_i) begin
      state_d     = IDLE;
      lane_mask_d = '1;
      excl_d      = '0;
      cnt_d       = '0;
      mismatch_d  = '0;
      retried_d   = 1'b0;
      wait_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_mask_q <= '1;
      excl_q      <= '0;
      cnt_q       <= '0;
      mismatch_q  <= '0;
      retried_q   <= 1'b0;
      wait_q      <= '0;
      mc_q        <= 1'b0;
      mh_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_mask_q <= lane_mask_d;
      excl_q      <= excl_d;
      cnt_q       <= cnt_d;
      mismatch_q  <= mismatch_d;
      retried_q   <= retried_d;
      wait_q      <= wait_d;
      mc_q        <= mc_d;
      mh_q        <= mh_d;
    end
  end

  assign multicycle_o  = mc_q;
  assign mulh_active_o = mh_q;
  assign retry_o       = (state_q == RETRY);
  assign fatal_o       = (state_q == FATAL);
  assign lane_mask_o   = lane_mask_q;
  assign mismatch_o    = mismatch_q;
  assign fault_cnt_o   = cnt_q;

endmodule

// File: tb/tb_cv32e40p_mult_tmr_ctrl.sv
// tb/tb_cv32e40p_mult_tmr_ctrl.sv - self-checking bench for the TMR multiplier controller
module tb_cv32e40p_mult_tmr_ctrl;

  logic             clk = 1'b0;
  logic             rst_n, enable_i, ex_ready_i, clear_i;
  logic [2:0][31:0] res;
  logic [2:0]       rdy, mc, mh;
  logic [31:0]      result_o;
  logic             ready_o, multicycle_o, mulh_active_o, retry_o, fatal_o;
  logic [2:0]       lane_mask_o, mismatch_o;
  logic [2:0][3:0]  fault_cnt_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_mult_tmr_ctrl #(.FAULT_THRESH(3), .CNT_W(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .ex_ready_i(ex_ready_i), .clear_i(clear_i),
    .result_i(res), .ready_i(rdy), .multicycle_i(mc), .mulh_active_i(mh),
    .result_o(result_o), .ready_o(ready_o), .multicycle_o(multicycle_o),
    .mulh_active_o(mulh_active_o), .retry_o(retry_o), .lane_mask_o(lane_mask_o),
    .mismatch_o(mismatch_o), .fatal_o(fatal_o), .fault_cnt_o(fault_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference vote: per-bit count of ones across three lanes, or the first active lane.
  function automatic logic [31:0] ref_vote(input logic [2:0][31:0] r, input logic [2:0] m);
    logic [31:0] v;
    int ones;
    v = r[0];
    if (m == 3'b111) begin
      for (int b = 0; b < 32; b++) begin
        ones = int'(r[0][b]) + int'(r[1][b]) + int'(r[2][b]);
        v[b] = (ones >= 2);
      end
    end else begin
      for (int i = 2; i >= 0; i--) if (m[i]) v = r[i];
    end
    return v;
  endfunction

  typedef struct {
    logic [31:0] r0, r1, r2;
    logic [2:0]  rdy, mc, mh;
    logic [31:0] exp_res;
    logic        exp_rdy, exp_mc, exp_mh;
  } vec_t;

  vec_t             vecs[6];
  logic [2:0]       m_mask, mmis;
  int               m_cnt[3];
  logic [2:0][31:0] r;
  logic [31:0]      exp_res;
  int               waits, bad, bitpos, n_act;
  logic             exp_mc, exp_mh;

  initial begin
    vecs[0] = '{32'h0F0F0F0F, 32'h00FF00FF, 32'hFFFF0000, 3'b111, 3'b000, 3'b000, 32'h0FFF000F, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h1, 32'h2, 32'h3, 3'b011, 3'b001, 3'b100, 32'h3, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111, 3'b010, 3'b000, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h0, 32'hFFFFFFFF, 32'h0, 3'b110, 3'b000, 3'b010, 32'h0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 3'b111, 3'b100, 3'b001, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{32'h80000001, 32'h80000000, 32'h00000001, 3'b101, 3'b000, 3'b000, 32'h80000001, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; enable_i = 1'b0; ex_ready_i = 1'b0; clear_i = 1'b0;
    res = '0; rdy = '0; mc = '0; mh = '0;
    step(); step();
    chk("reset_mask", lane_mask_o, 3'b111);
    chk("reset_cnt", fault_cnt_o, 12'h000);
    chk("reset_mismatch", mismatch_o, 3'b000);
    chk("reset_retry", retry_o, 1'b0);
    chk("reset_fatal", fatal_o, 1'b0);
    rst_n = 1'b1;
    step();

    // Vote table with no operation in flight
    for (int k = 0; k < 6; k++) begin
      res[0] = vecs[k].r0; res[1] = vecs[k].r1; res[2] = vecs[k].r2;
      rdy = vecs[k].rdy; mc = vecs[k].mc; mh = vecs[k].mh;
      #1;
      chk("tbl_result", result_o, vecs[k].exp_res);
      chk("tbl_ready", ready_o, vecs[k].exp_rdy);
      step();
      chk("tbl_multicycle", multicycle_o, vecs[k].exp_mc);
      chk("tbl_mulh", mulh_active_o, vecs[k].exp_mh);
    end
    mc = '0; mh = '0;

    // Single-lane fault under full TMR, then retirement after three faults
    res = {32'h12345679, 32'h12345678, 32'h12345678};
    rdy = 3'b111; enable_i = 1'b1; ex_ready_i = 1'b1;
    #1 chk("vote_single_fault", result_o, 32'h12345678);
    step();
    chk("mismatch_lane2", mismatch_o, 3'b100);
    chk("cnt_lane2_one", 32'(fault_cnt_o[2]), 32'd1);
    enable_i = 1'b0;
    step();
    chk("mismatch_pulse_width", mismatch_o, 3'b000);
    enable_i = 1'b1;
    step(); step();
    chk("retire_mask", lane_mask_o, 3'b011);
    chk("retire_cnt", 32'(fault_cnt_o[2]), 32'd3);
    enable_i = 1'b0;
    step();
    res = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000}; rdy = 3'b011;
    #1 chk("two_lane_select", result_o, 32'h0);
    chk("two_lane_ready", ready_o, 1'b1);

    // Two-lane disagreement: retry once, then fatal
    res = {32'h0, 32'h6, 32'h5}; rdy = 3'b111; enable_i = 1'b1; ex_ready_i = 1'b1;
    #1 chk("disagree_ready_low", ready_o, 1'b0);
    step();
    chk("retry_pulse", retry_o, 1'b1);
    step();
    chk("retry_one_cycle", retry_o, 1'b0);
    chk("not_yet_fatal", fatal_o, 1'b0);
    step();
    chk("second_disagree_fatal", fatal_o, 1'b1);
    chk("fatal_ready_low", ready_o, 1'b0);
    res = {32'h0, 32'h5, 32'h5};
    #1 chk("fatal_ready_stays_low", ready_o, 1'b0);
    chk("fatal_no_retry", retry_o, 1'b0);

    clear_i = 1'b1; enable_i = 1'b0;
    step();
    clear_i = 1'b0;
    chk("clear_fatal", fatal_o, 1'b0);
    chk("clear_mask", lane_mask_o, 3'b111);
    chk("clear_cnt", fault_cnt_o, 12'h000);
    #1 chk("clear_idle_ready", ready_o, 1'b1);

    // Readiness timeout on lane 1
    res = {32'h11, 32'h11, 32'h11}; rdy = 3'b101; enable_i = 1'b1; ex_ready_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) chk("timeout_not_early", mismatch_o, 3'b000);
    end
    chk("timeout_mismatch", mismatch_o, 3'b010);
    chk("timeout_cnt", 32'(fault_cnt_o[1]), 32'd1);
    chk("timeout_ready_two_lanes", ready_o, 1'b1);
    step();
    chk("timeout_complete_clean", mismatch_o, 3'b000);

    // enable_i dropped mid-operation
    res = {32'h9, 32'h7, 32'h7}; rdy = 3'b011;
    step(); step(); step();
    enable_i = 1'b0;
    step();
    chk("abort_cnt2", 32'(fault_cnt_o[2]), 32'd0);
    chk("abort_cnt1", 32'(fault_cnt_o[1]), 32'd1);
    chk("abort_mismatch", mismatch_o, 3'b000);
    enable_i = 1'b1;
    repeat (6) step();
    chk("abort_wait_restart", mismatch_o, 3'b000);
    enable_i = 1'b0;
    step();

    // clear_i wins over a same-cycle fault update
    rdy = 3'b111; enable_i = 1'b1; clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clear_prio_mismatch", mismatch_o, 3'b000);
    chk("clear_prio_cnt", fault_cnt_o, 12'h000);

    // Reset during BUSY with a pending mismatch
    rdy = 3'b011;
    step();
    rdy = 3'b111; rst_n = 1'b0;
    step();
    chk("rst_mid_mismatch", mismatch_o, 3'b000);
    chk("rst_mid_cnt", fault_cnt_o, 12'h000);
    chk("rst_mid_mask", lane_mask_o, 3'b111);
    rst_n = 1'b1; enable_i = 1'b0;
    step();

    // Dropping below two lanes via timeout
    res = {32'h2, 32'h1, 32'h1}; rdy = 3'b111; enable_i = 1'b1;
    step(); step(); step();
    chk("below2_mask", lane_mask_o, 3'b011);
    rdy = 3'b001;
    repeat (9) step();
    chk("below2_fatal", fatal_o, 1'b1);
    chk("below2_mismatch", mismatch_o, 3'b010);
    clear_i = 1'b1; enable_i = 1'b0;
    step();
    clear_i = 1'b0;

    // Randomized operations against the reference model
    m_mask = 3'b111;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    for (int op = 0; op < 60; op++) begin
      if (op % 20 == 19) begin
        clear_i = 1'b1; enable_i = 1'b0;
        step();
        clear_i = 1'b0;
        m_mask = 3'b111;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        chk("rnd_clear_mask", lane_mask_o, 3'b111);
      end
      n_act = 0;
      for (int i = 0; i < 3; i++) if (m_mask[i]) n_act++;
      exp_res = $urandom;
      r[0] = exp_res; r[1] = exp_res; r[2] = exp_res;
      if (n_act == 3 && $urandom_range(0, 2) == 0) begin
        bad = $urandom_range(0, 2);
        bitpos = $urandom_range(0, 31);
        r[bad][bitpos] = ~r[bad][bitpos];
      end
      exp_res = ref_vote(r, m_mask);
      res = r; enable_i = 1'b1; ex_ready_i = 1'b0;
      waits = $urandom_range(0, 3);
      for (int w = 0; w <= waits; w++) begin
        if (w == waits) begin
          rdy = 3'b111; ex_ready_i = 1'b1;
        end else begin
          rdy = 3'($urandom);
        end
        mc = 3'($urandom); mh = 3'($urandom);
        exp_mc = |(mc & m_mask); exp_mh = |(mh & m_mask);
        #1;
        chk("rnd_result", result_o, exp_res);
        chk("rnd_ready", ready_o, (rdy & m_mask) == m_mask);
        step();
        chk("rnd_multicycle", multicycle_o, exp_mc);
        chk("rnd_mulh", mulh_active_o, exp_mh);
      end
      mmis = '0;
      for (int i = 0; i < 3; i++) begin
        if (m_mask[i] && r[i] != exp_res) begin
          mmis[i] = 1'b1;
          if (m_cnt[i] < 15) m_cnt[i]++;
          if (m_cnt[i] >= 3) m_mask[i] = 1'b0;
        end
      end
      chk("rnd_mismatch", mismatch_o, mmis);
      for (int i = 0; i < 3; i++) chk("rnd_cnt", 32'(fault_cnt_o[i]), m_cnt[i]);
      chk("rnd_mask", lane_mask_o, m_mask);
      chk("rnd_fatal", fatal_o, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
